dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder serving the CPU's MEM-stage data port: it accepts address, write data, `mem_w` and `dm_ctrl` from the pipeline and returns load data in the same cycle. It provides a word-organised RAM with byte/halfword lane writes, sign- or zero-extended reads, and a small MMIO register window with an LED register, a free-running cycle counter and misaligned-store error tracking.

## Interface
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words, power of two.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_w` in 1: store strobe for the current cycle.
- `addr` in 32: byte address from the ALU result.
- `wdata` in 32: store data.
- `dm_ctrl` in 3: access type.
  - 000 word.
  - 001 half, signed.
  - 010 half, unsigned.
  - 011 byte, signed.
  - 100 byte, unsigned.
  - 101–111 treated as word.
- `rdata` out 32: load data, combinational.
- `led` out 32: LED register contents.
- `err` out 1: sticky misaligned-store flag.

## Operation
- **Region decode.** `addr[31:28]==4'hF` selects MMIO; any other address selects RAM.
- **RAM indexing.** Word index is `addr[log2(DEPTH_WORDS)+1:2]`; out-of-range addresses wrap modulo depth.
- **Misalignment.**
  - Word access with `addr[1:0]!=0` is misaligned.
  - Half access with `addr[0]==1` is misaligned.
  - Byte accesses are never misaligned.
- **Store lanes.**
  - Byte: `wdata[7:0]` goes to lane `addr[1:0]`.
  - Half: `wdata[15:0]` goes to lanes {`addr[1]`,0} and {`addr[1]`,1}.
  - Word: all four lanes.
  - Unwritten lanes are preserved. Signedness is irrelevant for stores.
- **Misaligned store.** Suppressed entirely (no RAM or MMIO change). `ERR_CNT` increments, saturating at 16'hFFFF, and `STATUS[0]` sets.
- **Load.**
  - Word: returns the full word.
  - Half: selects the half by `addr[1]`, then sign- or zero-extends per `dm_ctrl`.
  - Byte: selects by `addr[1:0]`, then extends.
  - Misaligned loads return 32'h0 with no side effects. The CPU has no read strobe, so reads never update state.
- **MMIO registers.** Only `addr[3:2]` is decoded; `addr[27:4]` is ignored (aliases).
  - 0x0 `LED`: RW, lane-writable like RAM.
  - 0x4 `CYCLE`: RO, increments every clock and wraps at 2^32; writes are ignored.
  - 0x8 `ERR_CNT`: RO, 16-bit, read zero-extended; writes are ignored.
  - 0xC `STATUS`: bit0 = misaligned sticky, cleared by an aligned store with `wdata` bit0=1 in lane 0. Bits 31:1 read 0.
- MMIO loads apply the same lane select and extension as RAM loads.
- **Simultaneous set and clear of `STATUS[0]`.** This cannot occur in a single store, because a misaligned store is suppressed. If `STATUS[0]` and a clear coincide with the counter saturating, the clear applies and `ERR_CNT` holds.
- `err` = `STATUS[0]`; `led` = `LED`.

## Timing
- Load latency 0: `rdata` is a pure function of `addr`, `dm_ctrl` and current state.
- Stores commit on the rising edge where `mem_w=1`.
- A load to the same address in the same cycle as a store returns the pre-store value.
- `CYCLE` read in cycle N returns N, counting edges since reset release. A store in the same cycle does not affect it.
- **Reset (async assert, `rst_n=0`):**
  - `LED`=0, `CYCLE`=0, `ERR_CNT`=0, `STATUS`=0, so `led`=0 and `err`=0.
  - RAM contents are not reset (undefined until written).
  - Stores are ignored while `rst_n=0`.
- **Reset mid-operation.** A store coincident with reset assertion is lost. `CYCLE` restarts from 0 on the first edge after deassertion.
- No backpressure and no stall: every cycle is one complete transaction.

## Test plan
- **Word store/load.** Store 32'hDEADBEEF to 0x10 (word) → next cycle, load 0x10 word = DEADBEEF; same-cycle load returned the old value.
- **Lane stores and extended loads.** Word 0 at 0x20, then byte 0x80 to 0x23 and half 0x8001 to 0x20.
  - Word load of 0x20 = 80008001.
  - Byte-signed load of 0x23 = FFFFFF80.
  - Byte-unsigned load of 0x23 = 00000080.
  - Half-signed load of 0x20 = FFFF8001.
  - Half-unsigned load of 0x20 = 00008001.
- **Misaligned store.** Word store of 0x12345678 to 0x21 → RAM unchanged, `err`=1, `ERR_CNT`=1; word load of 0x21 = 0. Then store 1 to 0xF000000C → `err`=0, `ERR_CNT` stays 1.
- **LED and CYCLE.** Byte store 0xA5 to 0xF0000001 → `led`=0000A500. Load 0xF0000004 five cycles after reset release = 5. A store to 0xF0000004 leaves the count unchanged.
- **Wrap and saturation.** With `DEPTH_WORDS`=1024, store to 0x1000 → readable at 0x0. 70000 misaligned stores → `ERR_CNT` = 0000FFFF.
- **Async reset.** Assert `rst_n`=0 mid-sequence, between clock edges → `led`=0, `err`=0, `CYCLE` reads 0 immediately; the store presented during reset is not committed.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-port responder.
//   Word-organised RAM with byte/half lane stores and sign/zero-extended
//   loads, plus an MMIO window at addr[31:28]==4'hF holding LED, CYCLE,
//   ERR_CNT and STATUS registers.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   mem_w             store strobe (one transaction per cycle, no stall)
//   addr, wdata       byte address, store data
//   dm_ctrl           access type (word / half s,u / byte s,u)
//   rdata             combinational load data (pre-store value on a store)
//   led               LED register
//   err               sticky misaligned-store flag (STATUS[0])
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] rdata,
  output logic [31:0] led,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] led_q, cycle_q;
  logic [15:0] err_cnt_q;
  logic        status_q;

  // Access decode
  logic          is_mmio, is_byte, is_half, is_word, misal;
  logic          store_ok, store_bad, ram_we, led_we, status_clr;
  logic [3:0]    be;
  logic [31:0]   wlane, rword;
  logic [15:0]   hsel;
  logic [7:0]    bsel;
  logic [AW-1:0] idx;

  assign is_mmio = (addr[31:28] == 4'hF);
  assign is_half = (dm_ctrl == 3'd1) || (dm_ctrl == 3'd2);
  assign is_byte = (dm_ctrl == 3'd3) || (dm_ctrl == 3'd4);
  assign is_word = !is_half && !is_byte;   // 000 and 101..111
  assign misal   = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
  assign idx     = addr[AW+1:2];            // high bits dropped: wraps mod depth

  always_comb begin
    be    = 4'b1111;
    wlane = wdata;
    if (is_byte) begin
      be    = 4'b0001 << addr[1:0];
      wlane = {4{wdata[7:0]}};
    end else if (is_half) begin
      be    = addr[1] ? 4'b1100 : 4'b0011;
      wlane = {2{wdata[15:0]}};
    end
  end

  assign store_ok   = mem_w && !misal;
  assign store_bad  = mem_w && misal;
  assign ram_we     = rst_n && store_ok && !is_mmio;
  assign led_we     = store_ok && is_mmio && (addr[3:2] == 2'd0);
  // Lane 0 always carries wdata[7:0] regardless of access size, so the
  // clear only needs lane 0 enabled and wdata[0] set.
  assign status_clr = store_ok && is_mmio && (addr[3:2] == 2'd3) && be[0] && wdata[0];

  // RAM: not reset; writes gated off while reset is asserted
  always_ff @(posedge clk) begin
    if (ram_we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= '0;
      cycle_q   <= '0;
      err_cnt_q <= '0;
      status_q  <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (led_we)
        for (int i = 0; i < 4; i++)
          if (be[i]) led_q[8*i +: 8] <= wlane[8*i +: 8];
      // A misaligned store never carries a clear, so set/clear are exclusive.
      if (store_bad) begin
        status_q <= 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (status_clr) begin
        status_q <= 1'b0;
      end
    end
  end

  // Load path: pick source word, then lane select and extend
  always_comb begin
    rword = mem[idx];
    if (is_mmio) begin
      case (addr[3:2])
        2'd0:    rword = led_q;
        2'd1:    rword = cycle_q;
        2'd2:    rword = {16'h0, err_cnt_q};
        default: rword = {31'h0, status_q};
      endcase
    end
  end

  assign hsel = addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    case (addr[1:0])
      2'd0:    bsel = rword[7:0];
      2'd1:    bsel = rword[15:8];
      2'd2:    bsel = rword[23:16];
      default: bsel = rword[31:24];
    endcase
  end

  always_comb begin
    rdata = rword;
    if (misal)                rdata = 32'h0;
    else if (dm_ctrl == 3'd1) rdata = {{16{hsel[15]}}, hsel};
    else if (dm_ctrl == 3'd2) rdata = {16'h0, hsel};
    else if (dm_ctrl == 3'd3) rdata = {{24{bsel[7]}}, bsel};
    else if (dm_ctrl == 3'd4) rdata = {24'h0, bsel};
  end

  assign led = led_q;
  assign err = status_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed-vector bench for dmem_responder.
// Inputs change 1 time unit after a rising edge; outputs are sampled
// mid-cycle, well away from the active edge.
module tb_dmem_responder;
  localparam logic [2:0] W = 3'd0, HS = 3'd1, HU = 3'd2, BS = 3'd3, BU = 3'd4;
  localparam logic [31:0] A_LED = 32'hF000_0000, A_CYC = 32'hF000_0004,
                          A_ERR = 32'hF000_0008, A_STA = 32'hF000_000C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_w;
  logic [31:0] addr, wdata, rdata, led;
  logic [2:0]  dm_ctrl;
  logic        err;
  int          n_chk = 0, n_err = 0;
  logic [31:0] r;

  dmem_responder #(.DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .mem_w(mem_w), .addr(addr), .wdata(wdata),
    .dm_ctrl(dm_ctrl), .rdata(rdata), .led(led), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one store, committed on the next rising edge
  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    mem_w = 1'b1; addr = a; wdata = d; dm_ctrl = c;
    @(posedge clk); #1;
    mem_w = 1'b0;
  endtask

  // combinational load, no clock consumed
  task automatic ld(input logic [31:0] a, input logic [2:0] c, output logic [31:0] q);
    mem_w = 1'b0; addr = a; dm_ctrl = c;
    #1 q = rdata;
  endtask

  initial begin
    rst_n = 1'b0; mem_w = 1'b0; addr = '0; wdata = '0; dm_ctrl = W;
    repeat (3) @(posedge clk); #1;
    chk("rst_led", led, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    ld(A_CYC, W, r); chk("rst_cycle", r, 32'h0);
    ld(A_ERR, W, r); chk("rst_errcnt", r, 32'h0);

    // CYCLE counts edges since release
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    ld(A_CYC, W, r); chk("cycle_5", r, 32'd5);
    st(A_CYC, 32'hFFFF_FFFF, W);
    ld(A_CYC, W, r); chk("cycle_ro", r, 32'd6);

    // word store, same-cycle load sees old value
    st(32'h10, 32'h1111_1111, W);
    mem_w = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF; dm_ctrl = W;
    #1 chk("same_cycle_old", rdata, 32'h1111_1111);
    @(posedge clk); #1 mem_w = 1'b0;
    ld(32'h10, W, r); chk("word_ld", r, 32'hDEAD_BEEF);

    // lane stores and extended loads
    st(32'h20, 32'h0, W);
    st(32'h23, 32'h80, BU);
    st(32'h20, 32'h8001, HS);
    ld(32'h20, W,  r); chk("lane_word", r, 32'h8000_8001);
    ld(32'h23, BS, r); chk("byte_s", r, 32'hFFFF_FF80);
    ld(32'h23, BU, r); chk("byte_u", r, 32'h0000_0080);
    ld(32'h20, HS, r); chk("half_s", r, 32'hFFFF_8001);
    ld(32'h20, HU, r); chk("half_u", r, 32'h0000_8001);
    ld(32'h22, HS, r); chk("half_hi_s", r, 32'hFFFF_8000);
    ld(32'h21, BU, r); chk("byte1_u", r, 32'h0000_0080);
    ld(32'h20, 3'd7, r); chk("ctrl7_word", r, 32'h8000_8001);

    // misaligned store is suppressed and counted
    st(32'h21, 32'h1234_5678, W);
    ld(32'h20, W, r); chk("misal_ram_kept", r, 32'h8000_8001);
    chk("misal_err", {31'h0, err}, 32'h1);
    ld(A_ERR, W, r); chk("misal_cnt", r, 32'h1);
    ld(A_STA, W, r); chk("status_set", r, 32'h1);
    ld(32'h21, W, r); chk("misal_ld", r, 32'h0);
    ld(32'h23, HU, r); chk("misal_half_ld", r, 32'h0);
    st(32'h23, 32'h0, HU);   // misaligned half store
    ld(A_ERR, W, r); chk("misal_half_cnt", r, 32'h2);
    st(A_STA + 32'h1, 32'h1, BU);  // lane 1 only: no clear
    chk("status_no_clr", {31'h0, err}, 32'h1);
    st(A_STA, 32'h1, W);
    chk("status_clr", {31'h0, err}, 32'h0);
    ld(A_ERR, W, r); chk("cnt_after_clr", r, 32'h2);

    // LED lane write and MMIO extension/aliasing
    st(32'hF000_0001, 32'h0000_00A5, BS);
    chk("led_byte", led, 32'h0000_A500);
    ld(32'hF000_0001, BS, r); chk("led_bs", r, 32'hFFFF_FFA5);
    ld(32'hF000_0000, HU, r); chk("led_hu", r, 32'h0000_A500);
    ld(32'hF123_4560, W,  r); chk("led_alias", r, 32'h0000_A500);

    // half store to upper half
    st(32'h22, 32'hABCD_1234, HU);
    ld(32'h20, W, r); chk("half_hi_st", r, 32'h1234_8001);

    // wrap
    st(32'h1000, 32'hCAFE_F00D, W);
    ld(32'h0, W, r); chk("wrap", r, 32'hCAFE_F00D);

    // saturation, then clear at saturation holds the count
    mem_w = 1'b1; addr = 32'h1; wdata = 32'h0; dm_ctrl = W;
    repeat (70000) @(posedge clk);
    #1 mem_w = 1'b0;
    ld(A_ERR, W, r); chk("err_sat", r, 32'h0000_FFFF);
    chk("err_sat_flag", {31'h0, err}, 32'h1);
    st(32'h1, 32'h0, W);
    ld(A_ERR, W, r); chk("err_sat_hold", r, 32'h0000_FFFF);
    st(A_STA, 32'h1, BU);
    chk("clr_at_sat", {31'h0, err}, 32'h0);
    ld(A_ERR, W, r); chk("cnt_at_sat_clr", r, 32'h0000_FFFF);

    // async reset mid-sequence with stores presented
    st(32'h40, 32'h55, W);
    st(32'h2, 32'h0, W);     // set err again
    mem_w = 1'b1; addr = 32'h40; wdata = 32'h99; dm_ctrl = W;
    #2 rst_n = 1'b0;
    #1 chk("arst_led", led, 32'h0);
    chk("arst_err", {31'h0, err}, 32'h0);
    addr = A_CYC; #1 chk("arst_cycle", rdata, 32'h0);
    addr = 32'h40; @(posedge clk); #1;
    addr = A_LED; wdata = 32'h7777_7777; @(posedge clk); #1;
    mem_w = 1'b0; rst_n = 1'b1;
    chk("arst_led_lost", led, 32'h0);
    ld(32'h40, W, r); chk("arst_ram_lost", r, 32'h55);
    @(posedge clk); #1;
    ld(A_CYC, W, r); chk("arst_cycle_restart", r, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
